// File: rtl/reg_readback_tx.sv
// reg_readback_tx: on request, snapshots one 4-register bank from the flattened
// register bus and sends it over a UART line (8N1, LSB first, idle high) as a
// header byte followed by the four register bytes, lowest address first.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   reg_data  flattened register array, register k at [8k+7:8k]
//   req       readback request, sampled every clock while idle
//   req_bank  bank to read (registers 4*bank .. 4*bank+3)
//   tx        serial data out, idle 1
//   busy      high from acceptance until the last stop bit completes
//   done      one-cycle pulse on the final clock of the last stop bit
module reg_readback_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter logic [3:0]  HDR_TAG      = 4'h5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [127:0]   reg_data,
   input  logic           req,
   input  logic [1:0]     req_bank,
   output logic           tx,
   output logic           busy,
   output logic           done
);

   localparam int unsigned CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned LAST_BYTE = 4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic [1:0]       state,    state_nxt;
   logic [CNT_W-1:0] cnt,      cnt_nxt;
   logic [2:0]       bit_idx,  bit_idx_nxt;
   logic [2:0]       byte_idx, byte_idx_nxt;
   logic [1:0]       bank,     bank_nxt;
   logic [31:0]      snap,     snap_nxt;
   logic             tx_nxt, busy_nxt, done_nxt;

   logic [1:0]       reg_sel;
   logic [7:0]       cur_byte;
   logic             bit_end;

   // Byte currently on the wire: header for index 0, else snapshot register.
   always_comb begin
      reg_sel  = 2'(byte_idx - 3'd1);
      cur_byte = (byte_idx == 3'd0) ? {HDR_TAG, 2'b00, bank}
                                    : snap[{reg_sel, 3'b000} +: 8];
   end

   assign bit_end = (cnt == '0);

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         bank     <= '0;
         snap     <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         byte_idx <= byte_idx_nxt;
         bank     <= bank_nxt;
         snap     <= snap_nxt;
         tx       <= tx_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = bit_end ? cnt : CNT_W'(cnt - 1'b1);
      bit_idx_nxt  = bit_idx;
      byte_idx_nxt = byte_idx;
      bank_nxt     = bank;
      snap_nxt     = snap;
      tx_nxt       = tx;
      busy_nxt     = busy;
      done_nxt     = 1'b0;

      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (req) begin
               state_nxt    = S_START;
               cnt_nxt      = CNT_RELOAD;
               bit_idx_nxt  = '0;
               byte_idx_nxt = '0;
               bank_nxt     = req_bank;
               snap_nxt     = reg_data[{req_bank, 5'd0} +: 32];
               tx_nxt       = 1'b0;
               busy_nxt     = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_nxt   = S_DATA;
               cnt_nxt     = CNT_RELOAD;
               bit_idx_nxt = '0;
               tx_nxt      = cur_byte[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_nxt = CNT_RELOAD;
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  bit_idx_nxt = 3'(bit_idx + 3'd1);
                  tx_nxt      = cur_byte[3'(bit_idx + 3'd1)];
               end
            end
         end
         S_STOP: begin
            // done is registered, so it is raised one cycle ahead of the last stop cycle.
            if (byte_idx == 3'(LAST_BYTE) && cnt == CNT_W'(1))
               done_nxt = 1'b1;
            if (bit_end) begin
               if (byte_idx < 3'(LAST_BYTE)) begin
                  state_nxt    = S_START;
                  cnt_nxt      = CNT_RELOAD;
                  byte_idx_nxt = 3'(byte_idx + 3'd1);
                  tx_nxt       = 1'b0;
               end else begin
                  state_nxt    = S_IDLE;
                  byte_idx_nxt = '0;
                  bit_idx_nxt  = '0;
                  busy_nxt     = 1'b0;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_readback_tx.sv
// Testbench for reg_readback_tx: a UART decoder pops expected bytes from a
// scoreboard queue filled when each request is issued; scenario tasks add
// timing, busy/done and reset checks.
module tb_reg_readback_tx;

   localparam int unsigned CPB = 4;

   logic         clk;
   logic         rst_n;
   logic [127:0] reg_data;
   logic         req;
   logic [1:0]   req_bank;
   logic         tx;
   logic         busy;
   logic         done;

   logic [7:0]   regs [16];
   logic [7:0]   exp_q [$];

   int vec_cnt;
   int err_cnt;
   int done_cnt;

   reg_readback_tx #(.CLKS_PER_BIT(CPB), .HDR_TAG(4'h5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .reg_data (reg_data),
      .req      (req),
      .req_bank (req_bank),
      .tx       (tx),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < 16; k++) reg_data[8*k +: 8] = regs[k];
   end

   always @(negedge clk) if (rst_n && done === 1'b1) done_cnt++;

   // UART receiver sampling mid-bit on the falling clock edge.
   int       dec_t;
   bit       dec_on;
   logic [7:0] dec_byte;
   logic [7:0] dec_exp;
   always @(negedge clk) begin
      if (!rst_n) begin
         dec_on = 1'b0;
      end else if (!dec_on) begin
         if (tx === 1'b0) begin
            dec_on = 1'b1;
            dec_t  = 0;
         end
      end else begin
         dec_t++;
         if (dec_t >= int'(CPB + CPB/2) && dec_t < int'(9*CPB) && (dec_t % int'(CPB)) == int'(CPB/2))
            dec_byte[(dec_t - int'(CPB)) / int'(CPB)] = tx;
         if (dec_t == int'(9*CPB + CPB/2)) begin
            dec_on = 1'b0;
            vec_cnt++;
            if (exp_q.size() == 0) begin
               err_cnt++;
               $display("FAIL rx_byte: got unexpected byte 0x%02h, expected none", dec_byte);
            end else begin
               dec_exp = exp_q.pop_front();
               if (dec_byte !== dec_exp || tx !== 1'b1) begin
                  err_cnt++;
                  $display("FAIL rx_byte: got 0x%02h stop=%b, expected 0x%02h stop=1",
                           dec_byte, tx, dec_exp);
               end
            end
         end
      end
   end

   task automatic push_expected(input logic [1:0] b);
      exp_q.push_back({4'h5, 2'b00, b});
      for (int i = 0; i < 4; i++) exp_q.push_back(regs[4*b + i]);
   endtask

   // Single-cycle request; returns at the falling edge of the first busy cycle.
   task automatic do_req(input logic [1:0] b);
      @(negedge clk);
      req_bank = b;
      req      = 1'b1;
      push_expected(b);
      @(negedge clk);
      req      = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      vec_cnt++;
      if (busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, busy, n);
      end
      repeat (2 * CPB * 10) @(negedge clk);
   endtask

   task automatic check_q_empty(input string name);
      vec_cnt++;
      if (exp_q.size() != 0) begin
         err_cnt++;
         $display("FAIL %s_queue: %0d bytes not received, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = 1'b0;
      req_bank = 2'd0;
      #23;
      vec_cnt++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_outputs: tx=%b busy=%b done=%b, expected 1 0 0", tx, busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic();
      int n = 0;
      int done_at = 0;
      regs[4] = 8'h11; regs[5] = 8'h22; regs[6] = 8'h33; regs[7] = 8'h44;
      done_cnt = 0;
      do_req(2'd1);
      while (busy === 1'b1 && n < 400) begin
         n++;
         if (done === 1'b1) done_at = n;
         @(negedge clk);
      end
      vec_cnt++;
      if (n != int'(50*CPB)) begin
         err_cnt++;
         $display("FAIL basic_busy_len: got %0d cycles, expected %0d", n, 50*CPB);
      end
      vec_cnt++;
      if (done_cnt != 1 || done_at != int'(50*CPB)) begin
         err_cnt++;
         $display("FAIL basic_done: count=%0d at=%0d, expected 1 at %0d", done_cnt, done_at, 50*CPB);
      end
      wait_idle("basic");
      check_q_empty("basic");
   endtask

   task automatic test_bit_timing();
      logic [9:0] frame;
      logic       pre_tx;
      frame = {1'b1, 8'h50, 1'b0};
      @(negedge clk);
      pre_tx = tx;
      req_bank = 2'd0;
      req = 1'b1;
      push_expected(2'd0);
      @(negedge clk);
      req = 1'b0;
      vec_cnt++;
      if (pre_tx !== 1'b1) begin
         err_cnt++;
         $display("FAIL timing_pre_idle: tx=%b before accept, expected 1", pre_tx);
      end
      for (int i = 0; i < int'(10*CPB); i++) begin
         vec_cnt++;
         if (tx !== frame[i / int'(CPB)]) begin
            err_cnt++;
            $display("FAIL timing_bit: cycle %0d tx=%b, expected %b", i, tx, frame[i / int'(CPB)]);
         end
         @(negedge clk);
      end
      wait_idle("timing");
      check_q_empty("timing");
   endtask

   task automatic test_snapshot();
      for (int k = 12; k < 16; k++) regs[k] = 8'hAA;
      do_req(2'd3);
      repeat (100) @(negedge clk);
      for (int k = 12; k < 16; k++) regs[k] = 8'h55;
      wait_idle("snapshot");
      check_q_empty("snapshot");
   endtask

   task automatic test_ignore_and_hold();
      int n;
      done_cnt = 0;
      do_req(2'd1);
      repeat (9) @(negedge clk);
      req = 1'b1; @(negedge clk); req = 1'b0;
      repeat (49) @(negedge clk);
      req = 1'b1; @(negedge clk); req = 1'b0;
      wait_idle("ignore");
      vec_cnt++;
      if (done_cnt != 1) begin
         err_cnt++;
         $display("FAIL ignore_done_count: got %0d, expected 1", done_cnt);
      end
      check_q_empty("ignore");

      @(negedge clk);
      req_bank = 2'd0;
      req = 1'b1;
      push_expected(2'd0);
      n = 0;
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      push_expected(2'd0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx !== 1'b0 && n < 10);
      req = 1'b0;
      vec_cnt++;
      if (n != 2) begin
         err_cnt++;
         $display("FAIL hold_retrigger_gap: start bit %0d cycles after done, expected 2", n);
      end
      wait_idle("hold");
      check_q_empty("hold");
   endtask

   task automatic test_reset_mid();
      regs[8] = 8'hC1; regs[9] = 8'hC2; regs[10] = 8'hC3; regs[11] = 8'hC4;
      do_req(2'd1);
      repeat (90) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL midreset_async: tx=%b busy=%b, expected 1 0", tx, busy);
      end
      exp_q.delete();
      done_cnt = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vec_cnt++;
      if (done_cnt != 0 || tx !== 1'b1 || busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL midreset_quiet: done_cnt=%0d tx=%b busy=%b, expected 0 1 0", done_cnt, tx, busy);
      end
      do_req(2'd2);
      wait_idle("midreset");
      vec_cnt++;
      if (done_cnt != 1) begin
         err_cnt++;
         $display("FAIL midreset_after_done: got %0d, expected 1", done_cnt);
      end
      check_q_empty("midreset");
   endtask

   task automatic test_sweep();
      for (int k = 0; k < 16; k++) regs[k] = 8'(k);
      for (int b = 0; b < 4; b++) begin
         do_req(2'(b));
         wait_idle("sweep");
      end
      check_q_empty("sweep");
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      done_cnt = 0;
      dec_on = 1'b0;
      for (int k = 0; k < 16; k++) regs[k] = 8'h00;
      test_reset();
      test_basic();
      test_bit_timing();
      test_snapshot();
      test_ignore_and_hold();
      test_reset_mid();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
